// File: rtl/prng.sv
// prng -- multiplicative congruential generator: rand_o = (a * X) mod m.
//
// X is the external seed, or the previous result when cont=1 and a result
// exists since reset. The 64-bit product is reduced serially, one product
// bit per cycle, by restoring shift-subtract.
//
// Ports
//   clk     rising-edge clock
//   rst     synchronous active-high reset (wins over start)
//   m       modulus, unsigned (m=0 yields 0)
//   a       multiplier, unsigned
//   seed    external seed, unsigned
//   start   level request, held high until done
//   cont    1 = chain from the last result instead of seed
//   done    result valid / handshake acknowledge
//   rand_o  registered result ("rand" is a reserved word in SystemVerilog)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start; operands latched on acceptance
// S_MUL    | form 64-bit product a*X
// S_REDUCE | 64 shift-subtract steps, then write remainder to rand_o
// S_DONE   | done=1 until start is seen low

module prng (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] m,
   input  logic [31:0] a,
   input  logic [31:0] seed,
   input  logic        start,
   input  logic        cont,
   output logic        done,
   output logic [31:0] rand_o
);

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_REDUCE, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [31:0] m_q, m_d;
   logic [31:0] a_q, a_d;
   logic [31:0] x_q, x_d;
   logic [63:0] prod_q, prod_d;
   logic [31:0] rem_q, rem_d;
   logic [6:0]  cnt_q, cnt_d;
   logic [31:0] rand_q, rand_d;
   logic        have_q, have_d;

   logic [32:0] rem_shift;
   logic        rem_ge;
   logic [31:0] rem_next;

   // One restoring step. The running remainder stays below m, so the
   // shifted value fits 33 bits and the difference always fits 32 bits.
   always_comb begin
      rem_shift = {rem_q, prod_q[63]};
      rem_ge    = (rem_shift >= {1'b0, m_q});
      rem_next  = rem_ge ? (rem_shift[31:0] - m_q) : rem_shift[31:0];
   end

   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      a_d     = a_q;
      x_d     = x_q;
      prod_d  = prod_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      rand_d  = rand_q;
      have_d  = have_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               m_d     = m;
               a_d     = a;
               x_d     = (cont && have_q) ? rand_q : seed;
               state_d = S_MUL;
            end
         end
         S_MUL: begin
            prod_d  = 64'(a_q) * 64'(x_q);
            rem_d   = '0;
            cnt_d   = 7'd64;
            state_d = S_REDUCE;
         end
         S_REDUCE: begin
            // down-counter: terminal count 0 means all 64 bits consumed
            if (cnt_q != 7'd0) begin
               rem_d  = rem_next;
               prod_d = {prod_q[62:0], 1'b0};
               cnt_d  = cnt_q - 7'd1;
            end else begin
               rand_d  = (m_q == 32'd0) ? 32'd0 : rem_q;
               have_d  = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (!start) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         m_q     <= '0;
         a_q     <= '0;
         x_q     <= '0;
         prod_q  <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         rand_q  <= '0;
         have_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         a_q     <= a_d;
         x_q     <= x_d;
         prod_q  <= prod_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         rand_q  <= rand_d;
         have_q  <= have_d;
      end
   end

   assign done   = (state_q == S_DONE);
   assign rand_o = rand_q;

endmodule

// File: tb/tb_prng.sv
module tb_prng;

   localparam logic [31:0] MODP = 32'd2147483647;
   localparam logic [31:0] MULT = 32'd16807;
   localparam int          LAT  = 66;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] m_i = '0, a_i = '0, seed_i = '0;
   logic        start = 1'b0, cont_i = 1'b0;
   logic        done;
   logic [31:0] rand_o;

   int passes = 0;
   int checks = 0;
   int fails  = 0;
   logic [31:0] exp_q[$];

   prng dut (
      .clk    (clk),
      .rst    (rst),
      .m      (m_i),
      .a      (a_i),
      .seed   (seed_i),
      .start  (start),
      .cont   (cont_i),
      .done   (done),
      .rand_o (rand_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) passes++;
      else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] model(input logic [31:0] mm, input logic [31:0] aa,
                                         input logic [31:0] xx);
      logic [63:0] p;
      p = 64'(aa) * 64'(xx);
      if (mm == 32'd0) return 32'd0;
      return 32'(p % 64'(mm));
   endfunction

   // Drive a request at the falling edge; the next rising edge accepts it.
   task automatic drive_req(input logic [31:0] mm, input logic [31:0] aa,
                            input logic [31:0] ss, input logic cc);
      @(negedge clk);
      m_i = mm; a_i = aa; seed_i = ss; cont_i = cc; start = 1'b1;
   endtask

   // Accept edge, scramble inputs (operands must already be latched), then
   // count edges until done. drop_at>0 releases start after that many edges.
   task automatic wait_result(input int drop_at, output int lat);
      lat = -1;
      @(posedge clk); #1;
      m_i = $urandom; a_i = $urandom; seed_i = $urandom; cont_i = ~cont_i;
      for (int k = 1; k <= 100; k++) begin
         @(posedge clk); #1;
         if (k == drop_at) start = 1'b0;
         if (done) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic finish_result(input string tag, input int lat);
      logic [31:0] e;
      chk({tag, "_latency"}, 64'(lat), 64'(LAT));
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk({tag, "_rand"}, 64'(rand_o), 64'(e));
      end else begin
         chk({tag, "_scoreboard_empty"}, 64'(exp_q.size()), 64'd1);
      end
   endtask

   task automatic full_req(input string tag, input logic [31:0] mm, input logic [31:0] aa,
                           input logic [31:0] ss, input logic cc,
                           input logic [31:0] expv, input int hold);
      int lat;
      logic [31:0] held;
      drive_req(mm, aa, ss, cc);
      exp_q.push_back(expv);
      wait_result(0, lat);
      finish_result(tag, lat);
      held = rand_o;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         chk({tag, "_done_held"}, 64'(done), 64'd1);
      end
      @(negedge clk);
      start = 1'b0;
      @(posedge clk); #1;
      chk({tag, "_done_fall"}, 64'(done), 64'd0);
      chk({tag, "_rand_stable"}, 64'(rand_o), 64'(held));
   endtask

   initial begin
      int lat;
      logic [31:0] rm, ra, rs;

      repeat (3) @(posedge clk);
      #1;
      chk("reset_done", 64'(done), 64'd0);
      chk("reset_rand", 64'(rand_o), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      full_req("v0", MODP, MULT, 32'h7B818935, 1'b0, 32'h755735EB, 3);
      full_req("v1", MODP, MULT, 32'h142E4ECE, 1'b0, 32'h6C37C0BB, 1);
      full_req("v2", MODP, MULT, 32'h68493A1B, 1'b0, 32'h1F85F81A, 1);
      full_req("v3", MODP, MULT, 32'h73F12C81, 1'b0, 32'h5EA1049E, 1);

      full_req("chain0", MODP, MULT, 32'd1, 1'b0, 32'd16807, 1);
      full_req("chain1", MODP, MULT, 32'd5, 1'b1, 32'd282475249, 1);

      full_req("m_zero",   32'd0, MULT, 32'd123, 1'b0, 32'd0, 1);
      full_req("a_zero",   MODP, 32'd0, 32'd123, 1'b0, 32'd0, 1);
      full_req("seed_eq_m", MODP, MULT, MODP, 1'b0, 32'd0, 1);
      // 2^32 == 2 (mod 2^31-1), so 0xFFFFFFFF reduces to 1 and the result is a
      full_req("seed_max", MODP, MULT, 32'hFFFFFFFF, 1'b0, 32'd16807, 1);

      for (int i = 0; i < 4; i++) begin
         rm = $urandom | 32'h1;
         ra = $urandom;
         rs = $urandom;
         full_req("random", rm, ra, rs, 1'b0, model(rm, ra, rs), 1);
      end

      // start released mid-computation: result still produced, done for one cycle
      drive_req(MODP, MULT, 32'd2, 1'b0);
      exp_q.push_back(32'd33614);
      wait_result(10, lat);
      finish_result("drop", lat);
      @(posedge clk); #1;
      chk("drop_done_one_cycle", 64'(done), 64'd0);

      // reset during REDUCE, with a new request already asserted
      drive_req(MODP, MULT, 32'h12345678, 1'b0);
      @(posedge clk);
      repeat (30) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      m_i = MODP; a_i = MULT; seed_i = 32'd7; cont_i = 1'b1;
      @(posedge clk); #1;
      chk("midreset_done", 64'(done), 64'd0);
      chk("midreset_rand", 64'(rand_o), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      exp_q.push_back(32'd117649);
      wait_result(0, lat);
      finish_result("post_reset_seed", lat);
      @(negedge clk);
      start = 1'b0;
      @(posedge clk); #1;
      chk("post_reset_done_fall", 64'(done), 64'd0);

      chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
